rr_arb_hs: RTL and testbench

RR_ARB_HS -- requirements
Module: rr_arb_hs

---
 rtl/rr_arb_pkg.sv | 7 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_arb_hs.sv | 83 ++++++++
 tb/tb_rr_arb_hs.sv | 113 +++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: FSM state type and pointer wrap helper shared by rr_arb_hs.
package rr_arb_pkg;
  typedef enum logic {ST_IDLE, ST_BUSY} st_e;
  function automatic int ptr_inc(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational find-first-set over req, searching upward from ptr with wrap.
module rr_pick #(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = $clog2(REQCNT)
) (
  input  logic [REQCNT-1:0]   req,
  input  logic [REQWIDTH-1:0] ptr,
  output logic [REQWIDTH-1:0] idx,
  output logic                found
);
  logic [REQWIDTH:0]   s;
  logic [REQWIDTH-1:0] j;
  // Scanning downward lets the lowest rotated offset win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = REQCNT - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (REQWIDTH + 1)'(k);
      j = (s >= (REQWIDTH + 1)'(REQCNT)) ? REQWIDTH'(s - (REQWIDTH + 1)'(REQCNT)) : REQWIDTH'(s);
      if (req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arb_hs.sv
// rr_arb_hs: round-robin arbiter holding each grant for a whole handshake transaction.
// RR_ARB_WEIGHT_EN adds per-requester weighted credit (back-to-back regrants).
module rr_arb_hs
  import rr_arb_pkg::*;
#(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int WGTW     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [REQCNT-1:0]      req_i,
  input  logic [REQCNT-1:0]      last_i,
  input  logic [REQCNT*WGTW-1:0] weight_i,
  input  logic                   gnt_rdy_i,
  output logic [REQCNT-1:0]      gnt_o,
  output logic [REQWIDTH-1:0]    gnt_num_o,
  output logic                   gnt_val_o
);
  st_e                 state;
  logic [REQWIDTH-1:0] ptr, pidx, sel, nxt;
  logic                found, take, regrant, again, fin, fin_n;
  rr_pick #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH)) u_pick (
    .req  (req_i),
    .ptr  (ptr),
    .idx  (pidx),
    .found(found)
  );
  assign fin_n = gnt_rdy_i && req_i[gnt_num_o] && last_i[gnt_num_o];
  assign fin   = fin_n || !req_i[gnt_num_o];
  assign nxt   = REQWIDTH'(ptr_inc(int'(gnt_num_o), REQCNT));
`ifdef RR_ARB_WEIGHT_EN
  logic [WGTW-1:0] credit, wload;
  logic [WGTW-1:0] wgt [REQCNT];
  logic            hold;
  for (genvar i = 0; i < REQCNT; i++) begin : g_w
    assign wgt[i] = weight_i[i*WGTW +: WGTW];
  end
  assign wload   = (wgt[pidx] == '0) ? WGTW'(1) : wgt[pidx];
  assign regrant = hold && req_i[gnt_num_o];
  assign again   = fin_n && credit > WGTW'(1);
`else
  logic unused_weight;
  assign unused_weight = ^weight_i;
  assign regrant       = 1'b0;
  assign again         = 1'b0;
`endif
  assign take = regrant || found;
  assign sel  = regrant ? gnt_num_o : pidx;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_num_o <= '0;
      gnt_val_o <= 1'b0;
      gnt_o     <= '0;
`ifdef RR_ARB_WEIGHT_EN
      credit    <= '0;
      hold      <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      if (take) begin
        state     <= ST_BUSY;
        gnt_num_o <= sel;
        gnt_val_o <= 1'b1;
        gnt_o     <= REQCNT'(1) << sel;
      end
`ifdef RR_ARB_WEIGHT_EN
      hold <= 1'b0;
      if (found && !regrant) credit <= wload;
`endif
    end else if (fin) begin
      state     <= ST_IDLE;
      gnt_val_o <= 1'b0;
      gnt_o     <= '0;
      if (!again) ptr <= nxt;
`ifdef RR_ARB_WEIGHT_EN
      hold <= again;
      if (again) credit <= credit - WGTW'(1);
`endif
    end
  end
endmodule

// File: tb/tb_rr_arb_hs.sv
// tb_rr_arb_hs: directed self-checking bench for rr_arb_hs (REQCNT=5).
module tb_rr_arb_hs;
  localparam int N = 5;
  localparam int W = 3;
  localparam int G = 4;
  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   req_i = '0;
  logic [N-1:0]   last_i = '0;
  logic [N*G-1:0] weight_i = '0;
  logic           gnt_rdy_i = 1'b0;
  logic [N-1:0]   gnt_o;
  logic [W-1:0]   gnt_num_o;
  logic           gnt_val_o;
  int checks = 0;
  int passes = 0;
  int seq [8];
  always #5 clk_i = ~clk_i;
  rr_arb_hs #(.REQCNT(N), .REQWIDTH(W), .WGTW(G)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .last_i   (last_i),
    .weight_i (weight_i),
    .gnt_rdy_i(gnt_rdy_i),
    .gnt_o    (gnt_o),
    .gnt_num_o(gnt_num_o),
    .gnt_val_o(gnt_val_o)
  );
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic v, input int n);
    logic [N+W:0] obs, exp;
    obs = {gnt_val_o, gnt_num_o, gnt_o};
    exp = {v, W'(n), v ? (N'(1) << n) : N'(0)};
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s val/num/gnt obs=%b exp=%b", tag, obs, exp);
  endtask
  initial begin
    #1 chk("reset_async", 0, 0);
    step; chk("reset_held", 0, 0);
    rst_i = 1'b0;
    req_i = 5'b10110; gnt_rdy_i = 1'b1; last_i = '1;
    seq[0:5] = '{1, 2, 4, 1, 2, 4};
    for (int i = 0; i < 6; i++) begin
      step; chk("rr_grant", 1, seq[i]);
      step; chk("rr_idle", 0, seq[i]);
    end
    req_i = '0;
    step; chk("idle_noreq", 0, 4);
    req_i = 5'b01000; gnt_rdy_i = 1'b0; last_i = '0;
    step; chk("hold_grant", 1, 3);
    for (int i = 0; i < 4; i++) begin
      req_i[0] = ~req_i[0];
      step; chk("stall_hold", 1, 3);
    end
    gnt_rdy_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_i[0] = ~req_i[0];
      step; chk("beat_hold", 1, 3);
    end
    req_i[0] = ~req_i[0]; last_i = 5'b01000;
    step; chk("last_end", 0, 3);
    req_i = 5'b00001; last_i = '0;
    step; chk("after_3", 1, 0);
    last_i = '1;
    step; chk("end_0", 0, 0);
    req_i = 5'b10000;
    step; chk("grant_4", 1, 4);
    step; chk("end_4", 0, 4);
    req_i = 5'b10001;
    step; chk("wrap_0", 1, 0);
    step; chk("wrap_end", 0, 0);
    req_i = 5'b00100; last_i = '0;
    step; chk("grant_2", 1, 2);
    req_i = '0;
    step; chk("abort", 0, 2);
    req_i = 5'b00111;
    step; chk("ptr_after_abort", 1, 0);
    last_i = '1;
    step; chk("abort_chk_end", 0, 0);
    req_i = 5'b01000; last_i = '0;
    step; chk("pre_rst_grant", 1, 3);
    #2 rst_i = 1'b1;
    #1 chk("rst_mid", 0, 0);
    step; chk("rst_edge", 0, 0);
    rst_i = 1'b0;
    step; chk("post_rst_grant", 1, 3);
    last_i = '1;
    step; chk("post_rst_end", 0, 3);
    req_i = '0;
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    weight_i = {4'h1, 4'h1, 4'h0, 4'h3, 4'h1};
    req_i = 5'b00110; gnt_rdy_i = 1'b1; last_i = '1;
`ifdef RR_ARB_WEIGHT_EN
    seq = '{1, 1, 1, 2, 1, 1, 1, 2};
`else
    seq = '{1, 2, 1, 2, 1, 2, 1, 2};
`endif
    for (int i = 0; i < 8; i++) begin
      step; chk("wgt_grant", 1, seq[i]);
      step; chk("wgt_idle", 0, seq[i]);
    end
    req_i = '0;
    step;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
